// File: rtl/band_energy_pkg.sv
// Shared definitions for the acoustic front-end band-energy stage.
//
// Holds the stream word widths that are common with the power-spectrum
// block, the default band geometry, the FSM state encoding, the
// saturation ceiling and a small counter-width helper.
package band_energy_pkg;

  // Word widths shared with the power-spectrum producer.
  localparam int I_BW = 32;
  localparam int O_BW = 32;

  // Default band geometry: 16 bands of 8 bins each.
  localparam int BAND_W_DEF    = 8;
  localparam int NUM_BANDS_DEF = 16;

  // Largest value representable on a default-width output word.
  localparam logic [O_BW-1:0] SAT_MAX = {O_BW{1'b1}};

  // ACCUM sums bins into bands.
  // DISCARD drops the surplus bins of an over-long frame.
  typedef enum logic {
    ACCUM   = 1'b0,
    DISCARD = 1'b1
  } state_e;

  // Counter width able to hold 0..n-1. It is never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/band_energy_if.sv
// Unidirectional data/valid/last stream without backpressure.
//
// Ports (signals):
//   data  - payload word, W bits
//   valid - beat qualifier
//   last  - final beat of a frame, qualified by valid
// Modports:
//   master - drives the stream
//   slave  - receives the stream
interface band_energy_if #(
  parameter int W = 32
);

  logic [W-1:0] data;
  logic         valid;
  logic         last;

  modport master (output data, output valid, output last);
  modport slave  (input  data, input  valid, input  last);

endinterface

// File: rtl/band_energy_sat_acc.sv
// Band accumulator with an output clamp.
//
// The register is ACC_W = I_BW + log2(BAND_W) bits wide, so a full band
// of maximum-valued bins cannot wrap. sum_o shows the value the
// accumulator will hold after the current beat, clamped to O_BW bits.
// The parent can therefore register a finished band on the same edge
// that consumes the band's last bin.
//
// Ports:
//   clk_i, rst_i - clock, async active-high reset
//   clr_i        - synchronous clear
//   load_i       - first bin of a band: acc = data_i
//   add_i        - later bin of a band: acc += data_i
//   data_i       - power bin, I_BW bits
//   sum_o        - saturated post-beat sum, O_BW bits
module band_sat_acc
  import band_energy_pkg::*;
#(
  parameter int I_BW   = band_energy_pkg::I_BW,
  parameter int O_BW   = band_energy_pkg::O_BW,
  parameter int BAND_W = band_energy_pkg::BAND_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            add_i,
  input  logic [I_BW-1:0] data_i,
  output logic [O_BW-1:0] sum_o
);

  localparam int ACC_W = I_BW + $clog2(BAND_W);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // Compute the next accumulator value.
  // A load restarts the band. An add extends it. Otherwise the value holds.
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = ACC_W'(data_i);
    end else if (add_i) begin
      acc_d = acc_q + ACC_W'(data_i);
    end
  end

  // Store the accumulator. The synchronous clear mirrors the async reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Clamp to the output range.
  // Clamping is needed only when the accumulator is wider than the output.
  // In that case any set bit above O_BW means overflow.
  generate
    if (ACC_W > O_BW) begin : g_clamp
      assign sum_o = (|acc_d[ACC_W-1:O_BW]) ? {O_BW{1'b1}} : acc_d[O_BW-1:0];
    end else begin : g_pass
      assign sum_o = O_BW'(acc_d);
    end
  endgenerate

endmodule

// File: rtl/band_energy.sv
// Band energy summation for the acoustic front end.
//
// The block groups consecutive power bins into NUM_BANDS bands of BAND_W
// bins each. It emits one saturated energy per band and marks the final
// band of each frame with last. The frame length is checked against
// NUM_BANDS*BAND_W, and errors are flagged on a sticky err_o.
//
// Ports:
//   clk_i, rst_i - clock, async active-high reset
//   en_i         - enable; low clears all state synchronously
//   in_s         - power-bin stream (slave), I_BW bits
//   out_s        - band-energy stream (master), O_BW bits, registered
//   err_o        - sticky frame-length error, registered
module band_energy
  import band_energy_pkg::*;
#(
  parameter int I_BW      = band_energy_pkg::I_BW,
  parameter int O_BW      = band_energy_pkg::O_BW,
  parameter int BAND_W    = band_energy_pkg::BAND_W_DEF,
  parameter int NUM_BANDS = band_energy_pkg::NUM_BANDS_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  band_energy_if.slave  in_s,
  band_energy_if.master out_s,
  output logic         err_o
);

  localparam int FRAME_LEN = BAND_W * NUM_BANDS;
  localparam int BIN_CW    = cntWidth(BAND_W);
  localparam int BAND_CW   = cntWidth(NUM_BANDS);

  state_e             state_q;
  logic [BIN_CW-1:0]  binCnt_q;
  logic [BAND_CW-1:0] bandCnt_q;
  logic [O_BW-1:0]    data_q;
  logic               valid_q;
  logic               last_q;
  logic               err_q;

  logic               accBeat;
  logic               bandEnd;
  logic               frameEnd;
  logic [O_BW-1:0]    bandSum;

  // Decode the beat qualifiers.
  // A counted beat is a valid beat seen while accumulating.
  // The frame ends on the last bin of the last band, which is bin FRAME_LEN-1.
  assign accBeat  = in_s.valid && (state_q == ACCUM);
  assign bandEnd  = (binCnt_q == BIN_CW'(BAND_W - 1));
  assign frameEnd = bandEnd && (bandCnt_q == BAND_CW'(NUM_BANDS - 1));

  band_sat_acc #(
    .I_BW   (I_BW),
    .O_BW   (O_BW),
    .BAND_W (BAND_W)
  ) u_acc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (!en_i),
    .load_i (en_i && accBeat && (binCnt_q == '0)),
    .add_i  (en_i && accBeat && (binCnt_q != '0)),
    .data_i (in_s.data),
    .sum_o  (bandSum)
  );

  // FSM, bin/band counters and registered outputs.
  //
  // The output registers default to zero every cycle, so valid_o is a
  // one-cycle pulse following the edge that consumed the band-completing
  // bin.
  //
  // If a frame reaches its full length without last, the final band is
  // still emitted. The FSM then drops beats until the producer's last
  // arrives. If last arrives early, the partial band is flushed as the
  // frame's final band.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ACCUM;
      binCnt_q  <= '0;
      bandCnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (!en_i) begin
      state_q   <= ACCUM;
      binCnt_q  <= '0;
      bandCnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (in_s.valid) begin
            if (frameEnd) begin
              data_q    <= bandSum;
              valid_q   <= 1'b1;
              last_q    <= 1'b1;
              binCnt_q  <= '0;
              bandCnt_q <= '0;
              if (!in_s.last) begin
                state_q <= DISCARD;
              end
            end else if (in_s.last) begin
              data_q    <= bandSum;
              valid_q   <= 1'b1;
              last_q    <= 1'b1;
              err_q     <= 1'b1;
              binCnt_q  <= '0;
              bandCnt_q <= '0;
            end else if (bandEnd) begin
              data_q    <= bandSum;
              valid_q   <= 1'b1;
              binCnt_q  <= '0;
              bandCnt_q <= bandCnt_q + BAND_CW'(1);
            end else begin
              binCnt_q  <= binCnt_q + BIN_CW'(1);
            end
          end
        end
        DISCARD: begin
          if (in_s.valid) begin
            err_q <= 1'b1;
            if (in_s.last) begin
              state_q <= ACCUM;
            end
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign out_s.data  = data_q;
  assign out_s.valid = valid_q;
  assign out_s.last  = last_q;
  assign err_o       = err_q;

  // The derived frame length documents the geometry the counters decode.
  // This check rejects a configuration whose frame could not hold one bin.
  initial begin : p_frameLenCheck
    if (FRAME_LEN < 1) begin
      $fatal(1, "band_energy: empty frame geometry");
    end
  end

endmodule
